// File: rtl/pair_dispatcher_if.sv
// Signal bundle between the pair dispatcher, its cell memories and the filter bank.
// master = dispatcher side, slave = environment side.
interface pair_dispatcher_if #(
   parameter int NUM_FILTER = 7,
   parameter int ADDR_WIDTH = 7,
   parameter int PID_WIDTH  = 7,
   parameter int POS_WIDTH  = 32
);
   logic                                 start;
   logic                                 phase_in;
   logic [ADDR_WIDTH:0]                  num_nb;
   logic [NUM_FILTER*(ADDR_WIDTH+1)-1:0] num_ref;
   logic                                 ref_rd_en;
   logic [ADDR_WIDTH-1:0]                ref_rd_addr;
   logic [NUM_FILTER*3*POS_WIDTH-1:0]    ref_rd_data;
   logic                                 nb_rd_en;
   logic [ADDR_WIDTH-1:0]                nb_rd_addr;
   logic [3*POS_WIDTH-1:0]               nb_rd_data;
   logic [NUM_FILTER-1:0]                back_pressure;
   logic                                 all_buffer_empty;
   logic                                 phase;
   logic [NUM_FILTER-1:0]                input_valid;
   logic [PID_WIDTH-1:0]                 nb_id_in;
   logic [3*POS_WIDTH-1:0]               nb_pos;
   logic [NUM_FILTER*3*POS_WIDTH-1:0]    ref_pos;
   logic                                 busy;
   logic                                 done;

   modport master (
      input  start, phase_in, num_nb, num_ref, ref_rd_data, nb_rd_data,
             back_pressure, all_buffer_empty,
      output ref_rd_en, ref_rd_addr, nb_rd_en, nb_rd_addr, phase, input_valid,
             nb_id_in, nb_pos, ref_pos, busy, done
   );

   modport slave (
      output start, phase_in, num_nb, num_ref, ref_rd_data, nb_rd_data,
             back_pressure, all_buffer_empty,
      input  ref_rd_en, ref_rd_addr, nb_rd_en, nb_rd_addr, phase, input_valid,
             nb_id_in, nb_pos, ref_pos, busy, done
   );
endinterface

// File: rtl/pair_dispatcher.sv
// Pair stream source: holds one reference particle per filter and streams every
// home-cell particle past the filter bank, advancing the reference once the bank drains.
module pair_dispatcher #(
   parameter int NUM_FILTER = 7,
   parameter int ADDR_WIDTH = 7,
   parameter int PID_WIDTH  = 7,
   parameter int POS_WIDTH  = 32,
   parameter int DRAIN_WAIT = 24
) (
   input logic               clk,
   input logic               rst,
   pair_dispatcher_if.master bus
);
   localparam int CW = ADDR_WIDTH + 1;
   localparam int TW = 3 * POS_WIDTH;
   localparam int DW = $clog2(DRAIN_WAIT + 2);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_REF, S_LOAD_CAP, S_STREAM, S_DRAIN, S_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          r_q, r_d, n_q, n_d;
   logic [CW-1:0]          num_nb_q, num_nb_d, max_ref_q, max_ref_d;
   logic [NUM_FILTER*CW-1:0] num_ref_q, num_ref_d;
   logic [DW-1:0]          wait_q, wait_d;
   logic                   phase_q, phase_d, busy_q, busy_d, done_q, done_d;
   logic                   issue;
   logic [NUM_FILTER-1:0]  mask;

   logic                   vld_p1;
   logic [NUM_FILTER-1:0]  mask_p1, valid_p2;
   logic [PID_WIDTH-1:0]   id_p1, id_p2;
   logic [TW-1:0]          pos_p2;
   logic [NUM_FILTER*TW-1:0] ref_pos_q;

   function automatic logic [CW-1:0] max_count(input logic [NUM_FILTER*CW-1:0] cnt);
      logic [CW-1:0] m;
      m = '0;
      for (int i = 0; i < NUM_FILTER; i++)
         if (cnt[i*CW +: CW] > m) m = cnt[i*CW +: CW];
      return m;
   endfunction

   always_comb begin
      for (int i = 0; i < NUM_FILTER; i++)
         mask[i] = (r_q < num_ref_q[i*CW +: CW]);
      // a home-cell particle never pairs with itself
      if (n_q == r_q) mask[0] = 1'b0;
   end

   always_comb begin
      state_d   = state_q;
      r_d       = r_q;
      n_d       = n_q;
      num_nb_d  = num_nb_q;
      num_ref_d = num_ref_q;
      max_ref_d = max_ref_q;
      wait_d    = wait_q;
      phase_d   = phase_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      issue     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               num_nb_d  = bus.num_nb;
               num_ref_d = bus.num_ref;
               max_ref_d = max_count(bus.num_ref);
               phase_d   = bus.phase_in;
               r_d       = '0;
               n_d       = '0;
               busy_d    = 1'b1;
               state_d   = (bus.num_nb == '0 || max_ref_d == '0) ? S_DONE : S_LOAD_REF;
            end
         end
         S_LOAD_REF: state_d = S_LOAD_CAP;
         S_LOAD_CAP: begin
            n_d     = '0;
            state_d = S_STREAM;
         end
         S_STREAM: begin
            if (!(|bus.back_pressure)) begin
               issue = 1'b1;
               n_d   = n_q + 1'b1;
               if (n_q == num_nb_q - 1'b1) begin
                  wait_d  = '0;
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (wait_q != DW'(DRAIN_WAIT)) begin
               wait_d = wait_q + 1'b1;
            end else if (bus.all_buffer_empty) begin
               r_d     = r_q + 1'b1;
               state_d = (r_d == max_ref_q) ? S_DONE : S_LOAD_REF;
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         r_q       <= '0;
         n_q       <= '0;
         num_nb_q  <= '0;
         num_ref_q <= '0;
         max_ref_q <= '0;
         wait_q    <= '0;
         phase_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         r_q       <= r_d;
         n_q       <= n_d;
         num_nb_q  <= num_nb_d;
         num_ref_q <= num_ref_d;
         max_ref_q <= max_ref_d;
         wait_q    <= wait_d;
         phase_q   <= phase_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // p1: read in flight in the home memory; p2: registered pair outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1    <= 1'b0;
         mask_p1   <= '0;
         id_p1     <= '0;
         valid_p2  <= '0;
         id_p2     <= '0;
         pos_p2    <= '0;
         ref_pos_q <= '0;
      end else begin
         vld_p1 <= issue;
         if (issue) begin
            mask_p1 <= mask;
            id_p1   <= PID_WIDTH'(n_q[ADDR_WIDTH-1:0]);
         end
         valid_p2 <= vld_p1 ? mask_p1 : '0;
         if (vld_p1) begin
            id_p2  <= id_p1;
            pos_p2 <= bus.nb_rd_data;
         end
         if (state_q == S_LOAD_CAP) ref_pos_q <= bus.ref_rd_data;
      end
   end

   assign bus.ref_rd_en   = (state_q == S_LOAD_REF);
   assign bus.ref_rd_addr = r_q[ADDR_WIDTH-1:0];
   assign bus.nb_rd_en    = issue;
   assign bus.nb_rd_addr  = n_q[ADDR_WIDTH-1:0];
   assign bus.phase       = phase_q;
   assign bus.input_valid = valid_p2;
   assign bus.nb_id_in    = id_p2;
   assign bus.nb_pos      = pos_p2;
   assign bus.ref_pos     = ref_pos_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
endmodule

// File: doc/pair_dispatcher.md
Name: pair_dispatcher

Overview:
Source end of the filter-bank pair stream. It loads one reference particle per filter from NUM_FILTER reference-cell memories. It then streams every particle of the home (neighbour) cell past all filters, driving the shared neighbour bus and the per-filter valid mask, and stalls on back-pressure. Reference positions stay constant until the filter bank reports all buffers empty; only then does the block advance to the next reference index.

Parameters:
NUM_FILTER, 7, number of filters / reference cells (filter 0 = home cell)
ADDR_WIDTH, 7, particle address width per cell memory (max 128 particles)
PID_WIDTH, 7, particle id width driven on nb_id (equals address)
POS_WIDTH, 32, width of one position component incl. cell id; tuple = 3*POS_WIDTH
DRAIN_WAIT, 24, cycles to wait after last issued beat before sampling all_buffer_empty

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  pulse; begins a pass (ignored while busy)
phase_in  in  1  phase for this pass, latched on accepted start
num_nb  in  ADDR_WIDTH+1  home-cell particle count, latched on start
num_ref  in  NUM_FILTER*(ADDR_WIDTH+1)  per-filter ref-cell particle counts, latched on start
ref_rd_en  out  1  read strobe to all ref-cell memories
ref_rd_addr  out  ADDR_WIDTH  shared ref particle index
ref_rd_data  in  NUM_FILTER*3*POS_WIDTH  ref positions, valid 1 cycle after ref_rd_en
nb_rd_en  out  1  read strobe to home-cell memory
nb_rd_addr  out  ADDR_WIDTH  neighbour particle index
nb_rd_data  in  3*POS_WIDTH  neighbour position, valid 1 cycle after nb_rd_en
back_pressure  in  NUM_FILTER  from filter bank
all_buffer_empty  in  1  from filter bank
phase  out  1  latched phase_in
input_valid  out  NUM_FILTER  per-filter pair valid
nb_id_in  out  PID_WIDTH  neighbour particle id
nb_pos  out  3*POS_WIDTH  neighbour position (broadcast)
ref_pos  out  NUM_FILTER*3*POS_WIDTH  held reference positions
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at pass completion

Behaviour:
- Reset: all outputs 0, FSM to IDLE, counters 0. Reset mid-pass aborts immediately, with no done pulse.
- max_ref = max over i of num_ref[i]. If num_nb==0 or max_ref==0, a start causes IDLE->DONE. done pulses in the next cycle and no reads are issued.
- FSM states:
  - IDLE: on start, latch the inputs, set r=0, set busy=1, go to LOAD_REF.
  - LOAD_REF: ref_rd_en=1 and ref_rd_addr=r for 1 cycle. Next cycle, capture ref_rd_data into ref_pos. Set n=0 and go to STREAM.
  - STREAM: each cycle in which back_pressure==0, assert nb_rd_en with nb_rd_addr=n, then n++. When |back_pressure, hold nb_rd_en=0 and n unchanged. After issuing n==num_nb-1, go to DRAIN.
  - DRAIN: wait DRAIN_WAIT cycles, then wait until all_buffer_empty==1. Then r++. If r==max_ref, go to DONE; otherwise go to LOAD_REF.
  - DONE: done=1 for 1 cycle, busy=0, go to IDLE.
- Beat pipeline, for nb_rd_en issued in cycle t:
  - Read data arrives at t+1.
  - At the t+1 edge the block registers nb_pos, nb_id_in=addr and input_valid. These are visible in t+2, giving a fixed latency of 2.
  - input_valid is 0 in every cycle without a beat.
- input_valid mask: input_valid[i]=1 iff r < num_ref[i]. Exception: input_valid[0]=0 when n==r (self-pair in home cell is suppressed). A beat whose mask is all zero still consumes its cycle.
- Back-pressure response: a read issued in the cycle before back_pressure rises still completes. Up to 2 beats are in flight, which the filter threshold slack absorbs. Issue resumes the first cycle back_pressure==0.
- ref_pos and phase remain unchanged from LOAD_REF capture through the end of DRAIN. ref_pos holds its last value in IDLE.
- start while busy is ignored. Latched counts are immune to input changes mid-pass.

Test Plan:
- Reset during STREAM (n=2) -> next cycle: input_valid=0, busy=0, nb_rd_en=0, no done pulse. A subsequent start runs a full pass normally.
- num_nb=3, num_ref={2,1,0,0,0,0,0}, no back-pressure, all_buffer_empty=1 -> masks at r=0 are 0x02,0x03,0x03 for n=0..2; at r=1 they are 0x01,0x00,0x01. Total valid pairs: filter0 = 4, filter1 = 3. done pulses once.
- num_nb=8, back_pressure[3] high for cycles 3..6 of STREAM -> nb_rd_en low during exactly those cycles. All 8 nb_id_in values 0..7 appear in order, with none duplicated or lost.
- all_buffer_empty held 0 for 50 cycles after DRAIN_WAIT -> ref_rd_en stays low. ref_pos is unchanged until all_buffer_empty rises, then LOAD_REF occurs with r=1.
- num_nb=0 with start -> done pulses 2 cycles after start. ref_rd_en and nb_rd_en never assert.
- start asserted again mid-pass with different num_nb -> ignored. Pass completes with the originally latched counts and phase.
